mig_ctrl_dummy_model: RTL and testbench



---
 rtl/mig_ctrl_dummy_model.sv | 140 ++++++++++++++
 tb/tb_mig_ctrl_dummy_model.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_ctrl_dummy_model.sv
// mig_ctrl_dummy_model: behavioural stand-in for the DDR (MIG) user interface.
// Single-beat writes/reads against a small on-chip array, with MIG-like
// busy flags, a read-valid strobe and a UI clock/reset pair.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   ui_clk              copy of clk
//   ui_clk_sync_rst     active-high UI reset, held through calibration
//   wr_addr/wr_data     write word address/data, sampled at end of busy
//   wr_en / wr_busy     write request level / write in progress
//   rd_addr             read word address, sampled at end of busy
//   rd_en / rd_busy     read request level / read in progress
//   rd_data             registered read data, held until the next read
//   rd_data_valid       one-cycle strobe qualifying rd_data
module mig_ctrl_dummy_model #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 256,
    parameter int MEM_AW     = 10,
    parameter int CAL_CYCLES = 32,
    parameter int WR_LAT     = 4,
    parameter int RD_LAT     = 6
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ui_clk,
    output logic              ui_clk_sync_rst,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    output logic              wr_busy,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_en,
    output logic              rd_busy,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid
);

    localparam int LAT_MAX = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int CNT_MAX = (CAL_CYCLES > LAT_MAX) ? CAL_CYCLES : LAT_MAX;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DEPTH   = 1 << MEM_AW;

    typedef enum logic [1:0] {
        CAL,
        IDLE,
        WR,
        RD
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic               wr_commit;
    logic               rd_commit;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Upper address bits alias onto the implemented depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_addr[ADDR_W-1:MEM_AW],
                                rd_addr[ADDR_W-1:MEM_AW]};

    assign ui_clk = clk;

    // cnt counts edges spent in the current state; the commit happens on
    // the last edge of the window so late-presented address/data is used.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        wr_commit = 1'b0;
        rd_commit = 1'b0;
        unique case (state)
            CAL: begin
                if (cnt == CNT_W'(CAL_CYCLES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (wr_en) begin
                    state_n = WR;
                end else if (rd_en) begin
                    state_n = RD;
                end
            end
            WR: begin
                if (cnt == CNT_W'(WR_LAT - 1)) begin
                    wr_commit = 1'b1;
                    state_n   = IDLE;
                    cnt_n     = '0;
                end
            end
            RD: begin
                if (cnt == CNT_W'(RD_LAT - 1)) begin
                    rd_commit = 1'b1;
                    state_n   = IDLE;
                    cnt_n     = '0;
                end
            end
            default: begin
                state_n = CAL;
                cnt_n   = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change
    // cleanly on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= CAL;
            cnt             <= '0;
            ui_clk_sync_rst <= 1'b1;
            wr_busy         <= 1'b1;
            rd_busy         <= 1'b1;
            rd_data         <= '0;
            rd_data_valid   <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            ui_clk_sync_rst <= (state_n == CAL);
            wr_busy         <= (state_n == CAL) || (state_n == WR);
            rd_busy         <= (state_n == CAL) || (state_n == RD);
            rd_data_valid   <= rd_commit;
            if (rd_commit) begin
                rd_data <= mem[rd_addr[MEM_AW-1:0]];
            end
        end
    end

    // Storage is deliberately not reset; a reset only blocks the commit
    // because it forces the state back to CAL.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_mig_ctrl_dummy_model.sv
// tb_mig_ctrl_dummy_model: directed, table-driven bench for the DDR
// stand-in, with hand-written sequences for the multi-cycle corner cases.
module tb_mig_ctrl_dummy_model;

    localparam int AW  = 25;
    localparam int DW  = 256;
    localparam int CAL = 32;
    localparam int WRL = 4;
    localparam int RDL = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ui_clk;
    logic          ui_clk_sync_rst;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          wr_busy;
    logic [AW-1:0] rd_addr = '0;
    logic          rd_en = 1'b0;
    logic          rd_busy;
    logic [DW-1:0] rd_data;
    logic          rd_data_valid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    mig_ctrl_dummy_model #(
        .ADDR_W(AW), .DATA_W(DW), .MEM_AW(10),
        .CAL_CYCLES(CAL), .WR_LAT(WRL), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .rst(rst), .ui_clk(ui_clk),
        .ui_clk_sync_rst(ui_clk_sync_rst),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
        .wr_busy(wr_busy), .rd_addr(rd_addr), .rd_en(rd_en),
        .rd_busy(rd_busy), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!wr_busy && !rd_busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("idle_timeout", ok, 1'b1);
    endtask

    task automatic wait_cal(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!ui_clk_sync_rst) break;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        int n;
        wait_idle();
        wr_addr = a;
        wr_data = d;
        wr_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        k = cyc;
        chk("wr_busy_rise", wr_busy, 1'b1);
        chk("rd_busy_in_wr", rd_busy, 1'b0);
        n = 0;
        while (wr_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wr_busy_len", cyc - k, WRL);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int k;
        bit got;
        wait_idle();
        rd_addr = a;
        rd_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_en = 1'b0;
        k = cyc;
        chk("rd_busy_rise", rd_busy, 1'b1);
        chk("wr_busy_in_rd", wr_busy, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_data_valid) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rd_valid_seen", got, 1'b1);
        chk("rd_latency", cyc - k, RDL);
        chk("rd_data", rd_data, exp);
        chk("rd_busy_at_valid", rd_busy, 1'b0);
        @(negedge clk);
        chk("rd_valid_one_cycle", rd_data_valid, 1'b0);
        chk("rd_data_hold", rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int k;
        int last;
        int nval;
        bit vflag;
        bit bflag;
        logic [DW-1:0] dbe;
        logic [DW-1:0] pat;

        dbe = {8{32'hdeadbeef}};
        for (int i = 0; i < 20; i++)
            vecs.push_back('{1'b1, AW'(i), DW'(i * 9)});
        for (int i = 0; i < 20; i++)
            vecs.push_back('{1'b0, AW'(i), DW'(i * 9)});
        vecs.push_back('{1'b1, AW'(0), dbe});
        vecs.push_back('{1'b0, AW'(0), dbe});
        vecs.push_back('{1'b0, AW'(1024), dbe});
        vecs.push_back('{1'b1, AW'(2047), DW'(256'h55aa)});
        vecs.push_back('{1'b0, AW'(1023), DW'(256'h55aa)});
        vecs.push_back('{1'b0, AW'(19), DW'(171)});

        // Reset and calibration window.
        @(negedge clk);
        @(negedge clk);
        chk("rst_ui_rst", ui_clk_sync_rst, 1'b1);
        chk("rst_wr_busy", wr_busy, 1'b1);
        chk("rst_rd_busy", rd_busy, 1'b1);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_rd_valid", rd_data_valid, 1'b0);
        chk("ui_clk_copy", ui_clk, clk);
        rst = 1'b1;
        vflag = 1'b0;
        bflag = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rd_data_valid) vflag = 1'b1;
            if (!ui_clk_sync_rst) break;
            if (!wr_busy || !rd_busy) bflag = 1'b1;
        end
        chk("cal_cycles", n, CAL);
        chk("cal_busy_held", bflag, 1'b0);
        chk("cal_no_valid", vflag, 1'b0);
        chk("cal_wr_busy_low", wr_busy, 1'b0);
        chk("cal_rd_busy_low", rd_busy, 1'b0);

        // Table-driven writes and reads.
        foreach (vecs[i]) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data);
            else do_read(vecs[i].addr, vecs[i].data);
        end

        // Late address/data: presented only after wr_busy rises.
        wait_idle();
        pat = {8{32'h0badf00d}} ^ DW'(7);
        wr_addr = AW'(5);
        wr_data = '0;
        wr_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        chk("late_wr_busy", wr_busy, 1'b1);
        wr_addr = AW'(7);
        wr_data = pat;
        wait_idle();
        do_read(AW'(7), pat);
        do_read(AW'(5), DW'(45));

        // Held rd_en: back-to-back reads every RDL+1 cycles.
        pat = {8{32'h13572468}};
        do_write(AW'(3), pat);
        wait_idle();
        rd_addr = AW'(3);
        rd_en   = 1'b1;
        last = 0;
        nval = 0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rd_data_valid) begin
                nval++;
                chk("held_rd_data", rd_data, pat);
                if (last > 0) chk("held_rd_spacing", i - last, RDL + 1);
                else chk("held_rd_first", i, RDL + 1);
                last = i;
            end
        end
        rd_en = 1'b0;
        chk("held_rd_count", nval, 14);
        wait_idle();

        // Both enables in IDLE: write wins, then read sees the new data.
        pat = {8{32'hcafe0009}};
        wr_addr = AW'(9);
        wr_data = pat;
        rd_addr = AW'(9);
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        k = cyc;
        chk("both_wr_first", wr_busy, 1'b1);
        chk("both_rd_wait", rd_busy, 1'b0);
        vflag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (rd_busy) rd_en = 1'b0;
            if (rd_data_valid) begin
                vflag = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
        chk("both_rd_seen", vflag, 1'b1);
        chk("both_rd_data", rd_data, pat);
        chk("both_latency", cyc - k, WRL + 1 + RDL);
        wait_idle();

        // Reset mid-write: the commit must not happen.
        pat = {8{32'h11112222}};
        do_write(AW'(12), pat);
        do_read(AW'(12), pat);
        wait_idle();
        wr_addr = AW'(12);
        wr_data = {8{32'h99998888}};
        wr_en   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ui_rst", ui_clk_sync_rst, 1'b1);
        chk("midrst_rd_busy", rd_busy, 1'b1);
        chk("midrst_rd_data", rd_data, '0);
        chk("midrst_rd_valid", rd_data_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_cal(n);
        chk("midrst_cal", n, CAL);
        do_read(AW'(12), pat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
